// File: rtl/spi_mstr_pkg.sv
// rtl/spi_mstr_pkg.sv - shared state encoding, defaults and divider preset for the SPI master
package spi_mstr_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE        = 2'd0;
    localparam state_t SAMPLE_WAIT = 2'd1;
    localparam state_t SHIFT_WAIT  = 2'd2;
    localparam state_t FINAL       = 2'd3;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_DIV_W  = 5;
    localparam int DEF_NUM_SS = 2;

    // Divider preset: SCLK (counter MSB) high, first fall a quarter period later.
    function automatic int fp_val(input int div_w);
        return (1 << (div_w - 1)) + (1 << (div_w - 2)) - 1;
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// rtl/spi_sclk_gen.sv - SCLK divider with front-porch preload and sample/shift strobes
module spi_sclk_gen
    import spi_mstr_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    output logic sclk_o,
    output logic smpl_o,
    output logic shft_o
);

    localparam logic [DIV_W-1:0] FP_V   = DIV_W'(fp_val(DIV_W));
    localparam logic [DIV_W-1:0] SMPL_V = {1'b0, {(DIV_W-1){1'b1}}};
    localparam logic [DIV_W-1:0] ONE_V  = DIV_W'(1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    assign div_d = load_i ? FP_V : div_q + ONE_V;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q <= FP_V;
        end else begin
            div_q <= div_d;
        end
    end

    // smpl precedes the SCLK rise edge, shft precedes the SCLK fall edge.
    assign sclk_o = div_q[DIV_W-1];
    assign smpl_o = (div_q == SMPL_V);
    assign shft_o = &div_q;

endmodule

// File: rtl/spi_mstr_gen.sv
// rtl/spi_mstr_gen.sv - mode-3 SPI master with variable length and multiple slave selects
// SPI_MSTR_LSB_FIRST_EN selects LSB-first bit order; default is MSB-first.
module spi_mstr_gen
    import spi_mstr_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DIV_W  = DEF_DIV_W,
    parameter int NUM_SS = DEF_NUM_SS
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic                                          wrt_i,
    input  logic [DATA_W-1:0]                             cmd_i,
    input  logic [$clog2(DATA_W):0]                       len_i,
    input  logic [((NUM_SS > 1) ? $clog2(NUM_SS) : 1)-1:0] ss_sel_i,
    input  logic                                          miso_i,
    output logic                                          sclk_o,
    output logic                                          mosi_o,
    output logic [NUM_SS-1:0]                             ss_n_o,
    output logic                                          busy_o,
    output logic                                          done_o,
    output logic [DATA_W-1:0]                             rd_data_o
);

    localparam int LEN_W = $clog2(DATA_W) + 1;
    localparam int SS_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;
    localparam logic [LEN_W-1:0] DW_L  = LEN_W'(DATA_W);
    localparam logic [LEN_W-1:0] ONE_L = LEN_W'(1);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   n_q, n_d, cnt_q, cnt_d, len_eff;
    logic [SS_W-1:0]    ss_q, ss_d;
    logic [DATA_W-1:0]  shr_q, shr_d, shr_load, shr_next;
    logic               miso_q, miso_d, tap;
    logic [NUM_SS-1:0]  ss_n_q, ss_n_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic               smpl, shft, finish;

    assign finish  = (state_q == FINAL) && shft;
    assign len_eff = ((len_i == '0) || (len_i > DW_L)) ? DW_L : len_i;

    spi_sclk_gen #(.DIV_W(DIV_W)) u_sclk (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i ((state_q == IDLE) || finish),
        .sclk_o (sclk_o),
        .smpl_o (smpl),
        .shft_o (shft)
    );

`ifdef SPI_MSTR_LSB_FIRST_EN
    // Bits leave from [0]; received bits enter at [N-1] and walk down to [0].
    assign shr_load = cmd_i & ({DATA_W{1'b1}} >> (DW_L - len_eff));
    assign shr_next = (shr_q >> 1) | ({{(DATA_W-1){1'b0}}, miso_q} << (n_q - ONE_L));
    assign tap      = shr_q[0];
`else
    // Left-aligned so cmd[N-1] sits on the MSB; after N shifts the upper bits are zero.
    assign shr_load = cmd_i << (DW_L - len_eff);
    assign shr_next = {shr_q[DATA_W-2:0], miso_q};
    assign tap      = shr_q[DATA_W-1];
`endif

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        ss_d    = ss_q;
        shr_d   = shr_q;
        miso_d  = miso_q;
        busy_d  = busy_q;
        done_d  = done_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (wrt_i) begin
                    n_d     = len_eff;
                    ss_d    = ss_sel_i;
                    shr_d   = shr_load;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = SAMPLE_WAIT;
                end
            end
            SAMPLE_WAIT: begin
                if (smpl) begin
                    miso_d  = miso_i;
                    state_d = (cnt_q == n_q - ONE_L) ? FINAL : SHIFT_WAIT;
                end
            end
            SHIFT_WAIT: begin
                if (shft) begin
                    shr_d   = shr_next;
                    cnt_d   = cnt_q + ONE_L;
                    state_d = SAMPLE_WAIT;
                end
            end
            FINAL: begin
                if (shft) begin
                    shr_d   = shr_next;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        ss_n_d = '1;
        if ((state_q != IDLE) && !finish) begin
            for (int i = 0; i < NUM_SS; i++) begin
                if (ss_q == SS_W'(i)) ss_n_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            n_q     <= '0;
            cnt_q   <= '0;
            ss_q    <= '0;
            shr_q   <= '0;
            miso_q  <= 1'b0;
            ss_n_q  <= '1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            ss_q    <= ss_d;
            shr_q   <= shr_d;
            miso_q  <= miso_d;
            ss_n_q  <= ss_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign mosi_o    = busy_q & tap;
    assign ss_n_o    = ss_n_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign rd_data_o = shr_q;

endmodule

// File: tb/tb_spi_mstr_gen.sv
// tb/tb_spi_mstr_gen.sv - self-checking bench for spi_mstr_gen with slave model and scoreboard
module tb_spi_mstr_gen;

`ifdef SPI_MSTR_LSB_FIRST_EN
    localparam bit LSB = 1'b1;
`else
    localparam bit LSB = 1'b0;
`endif

    typedef struct {
        logic [15:0] cmd;
        logic [4:0]  len;
        logic        ss;
        logic [15:0] resp;
        logic [15:0] rd;
        int          nbits;
        int          lat;
        logic [1:0]  ssn;
    } vec_t;

    typedef struct {
        logic [15:0] rd;
        logic [15:0] resp;
        logic [15:0] mosi_w;
        int          nbits;
        int          lat;
        logic [1:0]  ssn;
        logic        first;
        int          e0;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wrt = 1'b0;
    logic [15:0] cmd = '0;
    logic [4:0]  len = '0;
    logic        ss_sel = 1'b0;
    logic        miso = 1'b0;
    logic        sclk, mosi, busy, done;
    logic [1:0]  ss_n;
    logic [15:0] rd_data;

    logic        wrt3 = 1'b0;
    logic [15:0] cmd3 = '0;
    logic [4:0]  len3 = '0;
    logic [1:0]  ss_sel3 = '0;
    logic        miso3 = 1'b1;
    logic        sclk3, mosi3, busy3, done3;
    logic [2:0]  ss_n3;
    logic [15:0] rd_data3;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    exp_t sb[$];
    vec_t vecs[6];

    spi_mstr_gen #(.DATA_W(16), .DIV_W(5), .NUM_SS(2)) u_dut (
        .clk_i(clk), .rst_i(rst), .wrt_i(wrt), .cmd_i(cmd), .len_i(len), .ss_sel_i(ss_sel),
        .miso_i(miso), .sclk_o(sclk), .mosi_o(mosi), .ss_n_o(ss_n), .busy_o(busy),
        .done_o(done), .rd_data_o(rd_data)
    );

    spi_mstr_gen #(.DATA_W(16), .DIV_W(3), .NUM_SS(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .wrt_i(wrt3), .cmd_i(cmd3), .len_i(len3), .ss_sel_i(ss_sel3),
        .miso_i(miso3), .sclk_o(sclk3), .mosi_o(mosi3), .ss_n_o(ss_n3), .busy_o(busy3),
        .done_o(done3), .rd_data_o(rd_data3)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic slave_bit(input logic [15:0] resp, input int n, input int k);
        if (k >= n) return 1'b0;
        return LSB ? resp[k] : resp[n-1-k];
    endfunction

    // Slave model and scoreboard consumer, all sampled on the falling clk edge.
    logic        sclk_p = 1'b1, done_p = 1'b0, sclk_bad = 1'b0, first_mosi = 1'b0;
    logic [1:0]  ss_p = 2'b11, ss_seen = 2'b11;
    logic [15:0] cap = '0;
    int          rise_cnt = 0;
    exp_t        e;

    always @(negedge clk) begin
        sclk_p <= sclk;
        ss_p   <= ss_n;
        done_p <= done;
        if (!sclk && (&ss_n)) sclk_bad <= 1'b1;
        if (rst) begin
            sb.delete();
            rise_cnt <= 0;
            cap      <= '0;
        end else begin
            if ((&ss_p) && !(&ss_n) && (sb.size() > 0)) begin
                rise_cnt <= 0;
                cap      <= '0;
                miso     <= slave_bit(sb[0].resp, sb[0].nbits, 0);
            end
            if (sclk && !sclk_p && !(&ss_n)) begin
                cap      <= LSB ? (cap | (16'(mosi) << rise_cnt)) : {cap[14:0], mosi};
                if (rise_cnt == 0) first_mosi <= mosi;
                ss_seen  <= ss_n;
                rise_cnt <= rise_cnt + 1;
            end
            if (!sclk && sclk_p && !(&ss_n) && (sb.size() > 0))
                miso <= slave_bit(sb[0].resp, sb[0].nbits, rise_cnt);
            if (done && !done_p) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("rd_data", rd_data, e.rd);
                    check("done_latency", cyc - e.e0, e.lat);
                    check("sclk_rises", rise_cnt, e.nbits);
                    check("mosi_word", cap, e.mosi_w);
                    check("first_mosi", first_mosi, e.first);
                    check("ss_n_active", ss_seen, e.ssn);
                    check("ss_n_after_done", ss_n, 2'b11);
                    check("busy_at_done", busy, 1'b0);
                    check("sclk_low_ss_high", sclk_bad, 1'b0);
                end
            end
        end
    end

    task automatic wait_done(input string name);
        for (int k = 0; k < 2000 && !done; k++) @(negedge clk);
        check(name, done, 1'b1);
    endtask

    task automatic push_exp(input vec_t v, input int e0);
        exp_t x;
        logic [15:0] mask;
        mask     = 16'hFFFF >> (16 - v.nbits);
        x.rd     = v.rd;
        x.resp   = v.resp;
        x.mosi_w = v.cmd & mask;
        x.nbits  = v.nbits;
        x.lat    = v.lat;
        x.ssn    = v.ssn;
        x.first  = LSB ? v.cmd[0] : v.cmd[v.nbits-1];
        x.e0     = e0;
        sb.push_back(x);
    endtask

    task automatic run_vec(input vec_t v);
        push_exp(v, cyc + 1);
        cmd = v.cmd; len = v.len; ss_sel = v.ss; wrt = 1'b1;
        @(negedge clk);
        wrt = 1'b0;
        check("ss_n_at_accept", ss_n, 2'b11);
        check("busy_at_accept", busy, 1'b1);
        @(negedge clk);
        check("ss_n_selected", ss_n, v.ssn);
        wait_done("done_timeout");
        @(negedge clk);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        logic ss3_low;
        vec_t v;

        //          cmd       len    ss    resp      rd        n   lat  ssn
        vecs[0] = '{16'hA5C3, 5'd0,  1'b0, 16'h3C5A, 16'h3C5A, 16, 521, 2'b10};
        vecs[1] = '{16'h00F0, 5'd8,  1'b1, 16'h0081, 16'h0081,  8, 265, 2'b01};
        vecs[2] = '{16'h0001, 5'd4,  1'b0, 16'h0001, 16'h0001,  4, 137, 2'b10};
        vecs[3] = '{16'hFFFF, 5'd1,  1'b1, 16'h0000, 16'h0000,  1,  41, 2'b01};
        vecs[4] = '{16'h1357, 5'd20, 1'b0, 16'hFFFF, 16'hFFFF, 16, 521, 2'b10};
        vecs[5] = '{16'h8001, 5'd16, 1'b1, 16'h8001, 16'h8001, 16, 521, 2'b01};

        repeat (3) @(negedge clk);
        check("rst_ss_n", ss_n, 2'b11);
        check("rst_sclk", sclk, 1'b1);
        check("rst_mosi", mosi, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rd_data", rd_data, 16'h0000);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // wrt re-pulsed mid-transfer and held through done
        v  = vecs[0];
        e0 = cyc + 1;
        push_exp(v, e0);
        cmd = v.cmd; len = v.len; ss_sel = v.ss; wrt = 1'b1;
        @(negedge clk);
        wrt = 1'b0;
        while (cyc < e0 + 100) @(negedge clk);
        v = '{16'h0F0F, 5'd8, 1'b0, 16'h005A, 16'h005A, 8, 265, 2'b10};
        push_exp(v, e0 + 522);
        cmd = v.cmd; len = v.len; ss_sel = v.ss; wrt = 1'b1;
        @(negedge clk);
        check("busy_ignores_wrt", busy, 1'b1);
        check("done_ignores_wrt", done, 1'b0);
        wait_done("hold_done1_timeout");
        @(negedge clk);
        check("retrigger_busy", busy, 1'b1);
        check("retrigger_done_clear", done, 1'b0);
        wrt = 1'b0;
        wait_done("hold_done2_timeout");
        @(negedge clk);

        // reset in the middle of a transfer, then a clean transfer
        v  = '{16'h1234, 5'd0, 1'b0, 16'hBEEF, 16'hBEEF, 16, 521, 2'b10};
        e0 = cyc + 1;
        push_exp(v, e0);
        cmd = v.cmd; len = v.len; ss_sel = v.ss; wrt = 1'b1;
        @(negedge clk);
        wrt = 1'b0;
        while (cyc < e0 + 200) @(negedge clk);
        check("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_ss_n", ss_n, 2'b11);
        check("mid_rst_sclk", sclk, 1'b1);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_mosi", mosi, 1'b0);
        check("mid_rst_rd_data", rd_data, 16'h0000);
        rst = 1'b0;
        @(negedge clk);
        run_vec(v);

        // DIV_W=3 instance: N=1, out-of-range slave select
        e0 = cyc + 1;
        cmd3 = 16'h0001; len3 = 5'd1; ss_sel3 = 2'd3; wrt3 = 1'b1;
        ss3_low = 1'b0;
        @(negedge clk);
        wrt3 = 1'b0;
        for (int k = 0; k < 200 && !done3; k++) begin
            if (ss_n3 != 3'b111) ss3_low = 1'b1;
            @(negedge clk);
        end
        check("div3_done", done3, 1'b1);
        check("div3_latency", cyc - e0, 11);
        check("div3_rd_data", rd_data3, 16'h0001);
        check("div3_no_ss_low", ss3_low, 1'b0);
        check("div3_busy", busy3, 1'b0);
        check("div3_sclk_idle", sclk3, 1'b1);

        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
